// File: rtl/alu_seq_if.sv
// Request/result bus between the decode/control unit and the execute-stage ALU.
interface alu_seq_if #(
   parameter int unsigned DATAWIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0]           ALUctrl;
   logic                 ALUsrc;
   logic [DATAWIDTH-1:0] ALUop1;
   logic [DATAWIDTH-1:0] regOp2;
   logic [DATAWIDTH-1:0] ImmOp;
   logic [DATAWIDTH-1:0] ALUout;
   logic                 EQ;
   logic                 out_valid;

   modport master (
      output in_valid, ALUctrl, ALUsrc, ALUop1, regOp2, ImmOp,
      input  in_ready, ALUout, EQ, out_valid
   );

   modport slave (
      input  in_valid, ALUctrl, ALUsrc, ALUop1, regOp2, ImmOp,
      output in_ready, ALUout, EQ, out_valid
   );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle RV32I integer ops plus iterative unsigned
// multiply/divide sharing one double-width accumulator, behind valid/ready.
module alu_seq #(
   parameter int unsigned DATAWIDTH = 32,
   parameter bit          MULDIV_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   alu_seq_if.slave   bus
);
   localparam int unsigned W   = DATAWIDTH;
   localparam int unsigned SHW = $clog2(DATAWIDTH);
   localparam int unsigned CW  = $clog2(DATAWIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0110;
   localparam logic [3:0] OP_SLL   = 4'b0111;
   localparam logic [3:0] OP_SRL   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    opb_q, opb_d;
   logic            hi_sel_q, hi_sel_d;
   logic            eq_pend_q, eq_pend_d;
   logic [W-1:0]    alu_out_q, alu_out_d;
   logic            eq_q, eq_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;

   logic [W-1:0]    op1, op2, single_res;
   logic [SHW-1:0]  shamt;
   logic            accept, eq_now, is_mul, is_div, op2_zero;
   logic [W:0]      mul_sum, div_shift, div_diff;
   logic            div_ge;
   logic [2*W-1:0]  mul_next, div_next;

   assign op1      = bus.ALUop1;
   assign op2      = bus.ALUsrc ? bus.ImmOp : bus.regOp2;
   assign shamt    = op2[SHW-1:0];
   assign eq_now   = (op1 == op2);
   assign op2_zero = (op2 == '0);
   assign accept   = bus.in_valid && in_ready_q;
   assign is_mul   = MULDIV_EN && ((bus.ALUctrl == OP_MUL) || (bus.ALUctrl == OP_MULHU));
   assign is_div   = MULDIV_EN && ((bus.ALUctrl == OP_DIVU) || (bus.ALUctrl == OP_REMU));

   // Single-cycle result; DIVU/REMU entries only matter for a zero divisor.
   always_comb begin
      single_res = '0;
      case (bus.ALUctrl)
         OP_ADD:  single_res = op1 + op2;
         OP_SUB:  single_res = op1 - op2;
         OP_AND:  single_res = op1 & op2;
         OP_OR:   single_res = op1 | op2;
         OP_XOR:  single_res = op1 ^ op2;
         OP_SLT:  single_res = W'($signed(op1) < $signed(op2));
         OP_SLTU: single_res = W'(op1 < op2);
         OP_SLL:  single_res = op1 << shamt;
         OP_SRL:  single_res = op1 >> shamt;
         OP_SRA:  single_res = W'($signed(op1) >>> shamt);
         OP_DIVU: if (MULDIV_EN) single_res = '1;
         OP_REMU: if (MULDIV_EN) single_res = op1;
         default: single_res = '0;
      endcase
   end

   // Shift-add step: acc = {partial high, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[W-1:1]};

   // Restoring step: acc = {remainder, dividend bits shifting into quotient}.
   assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_ge    = !div_diff[W];
   assign div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      opb_d       = opb_q;
      hi_sel_d    = hi_sel_q;
      eq_pend_d   = eq_pend_q;
      alu_out_d   = alu_out_q;
      eq_d        = eq_q;
      out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               eq_pend_d = eq_now;
               cnt_d     = '0;
               if (is_mul) begin
                  state_d  = ST_MUL;
                  opb_d    = op1;
                  acc_d    = {{W{1'b0}}, op2};
                  hi_sel_d = (bus.ALUctrl == OP_MULHU);
               end else if (is_div && !op2_zero) begin
                  state_d  = ST_DIV;
                  opb_d    = op2;
                  acc_d    = {{W{1'b0}}, op1};
                  hi_sel_d = (bus.ALUctrl == OP_REMU);
               end else begin
                  alu_out_d   = single_res;
                  eq_d        = eq_now;
                  out_valid_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               alu_out_d   = hi_sel_q ? mul_next[2*W-1:W] : mul_next[W-1:0];
               eq_d        = eq_pend_q;
               out_valid_d = 1'b1;
            end
         end
         ST_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               alu_out_d   = hi_sel_q ? div_next[2*W-1:W] : div_next[W-1:0];
               eq_d        = eq_pend_q;
               out_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         hi_sel_q    <= 1'b0;
         eq_pend_q   <= 1'b0;
         alu_out_q   <= '0;
         eq_q        <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         hi_sel_q    <= hi_sel_d;
         eq_pend_q   <= eq_pend_d;
         alu_out_q   <= alu_out_d;
         eq_q        <= eq_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.ALUout    = alu_out_q;
   assign bus.EQ        = eq_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
endmodule
